// File: rtl/ev2_event_buffer.sv
// Receive-side endpoint of the ev2 event interface: a first-word-fall-through FIFO
// with free-space reporting, sticky overflow and the four-phase flush handshake.
module ev2_event_buffer #(
    parameter int DEPTH_BITS = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] ev_dat_i,
    input  logic                  ev_wr_i,
    output logic                  ev_full_o,
    output logic [15:0]           ev_count_o,
    input  logic                  ev_rst_i,
    output logic                  ev_rst_ack_o,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  valid_o,
    output logic                  overflow_o,
    input  logic                  ovf_clr_i
);

    localparam int          DEPTH   = 1 << DEPTH_BITS;
    localparam int          PW      = DEPTH_BITS + 1;
    localparam logic [15:0] CNT_RST = (DEPTH > 65535) ? 16'hFFFF : 16'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, occ_d;
    logic [31:0]           free_d;
    logic [15:0]           count_d;
    logic                  idle, flush, full_int, wr_acc, pop, ovf_set, valid_d;

    always_comb begin
        state_d      = state_q;
        idle         = 1'b0;
        flush        = 1'b0;
        ev_rst_ack_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idle = 1'b1;
                if (ev_rst_i) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush   = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                ev_rst_ack_o = 1'b1;
                if (!ev_rst_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The output register is a copy of mem[rd_ptr]; a word only leaves the RAM
    // when it is popped, so the RAM alone defines full/empty and occupancy.
    always_comb begin
        full_int = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
        wr_acc   = ev_wr_i && idle && !full_int;
        ovf_set  = ev_wr_i && idle && full_int;
        pop      = rd_i && valid_o && idle;
        wr_ptr_d = flush ? '0 : wr_ptr + PW'(wr_acc);
        rd_ptr_d = flush ? '0 : rd_ptr + PW'(pop);
        valid_d  = !flush && (wr_ptr != rd_ptr_d);
        occ_d    = wr_ptr_d - rd_ptr_d;
        free_d   = 32'(DEPTH) - 32'(occ_d);
        count_d  = (free_d > 32'h0000_FFFF) ? 16'hFFFF : free_d[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr[DEPTH_BITS-1:0]] <= ev_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            valid_o    <= 1'b0;
            dat_o      <= '0;
            ev_full_o  <= 1'b0;
            ev_count_o <= CNT_RST;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            valid_o    <= valid_d;
            if (valid_d) dat_o <= mem[rd_ptr_d[DEPTH_BITS-1:0]];
            ev_full_o  <= occ_d[DEPTH_BITS];
            ev_count_o <= count_d;
            // A new overflow event takes priority over a coincident clear.
            if (ovf_set)        overflow_o <= 1'b1;
            else if (ovf_clr_i) overflow_o <= 1'b0;
        end
    end

endmodule
